// File: rtl/vga_frame_sig.sv
// Video frame signature: per-frame CRC-32 of active pixels plus line/width checks.
// Define VGA_FRAME_SIG_TIMING_EN to also measure h_total/v_total; otherwise they are tied to 0.
module vga_frame_sig #(
    parameter int RW       = 5,
    parameter int GW       = 6,
    parameter int BW       = 5,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CW       = 12,
    parameter int SYNC_NEG = 1
) (
    input  logic          pclk,
    input  logic          reset_n,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          hactive,
    input  logic          vactive,
    input  logic [RW-1:0] red,
    input  logic [GW-1:0] green,
    input  logic [BW-1:0] blue,
    output logic          frame_done,
    output logic [15:0]   frame_count,
    output logic [31:0]   crc,
    output logic [CW-1:0] line_width,
    output logic [CW-1:0] line_count,
    output logic          width_err,
    output logic          height_err,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total
);

    localparam int            PW        = RW + GW + BW;
    localparam logic [31:0]   CRC_POLY  = 32'h04C11DB7;
    localparam logic [31:0]   CRC_INIT  = 32'hFFFFFFFF;
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] H_EXP     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_EXP     = CW'(V_ACTIVE);
    localparam logic          SYNC_IDLE = (SYNC_NEG != 0);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [PW-1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = PW - 1; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = (r << 1) ^ CRC_POLY;
            else              r = r << 1;
        end
        return r;
    endfunction

    state_t        state_q;
    logic          hs_q, vs_q, ha_q, va_q;
    logic [PW-1:0] pix_q;
    logic          vs_on_prev_q, ha_prev_q;

    logic [31:0]   crc_acc_q, crc_acc_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CW-1:0] line_cnt_q, line_cnt_d;
    logic [CW-1:0] pend_w_q, pend_w_d;
    logic          pend_werr_q, pend_werr_d;

    // Snapshot staged one cycle so the outputs and the pulse land together.
    logic          done_pend_q;
    logic [31:0]   stg_crc_q;
    logic [CW-1:0] stg_w_q, stg_lines_q;
    logic          stg_werr_q;
    logic [CW-1:0] snap_w, snap_lines;
    logic          snap_werr;

    logic          frame_done_q, width_err_q, height_err_q;
    logic [15:0]   frame_count_q;
    logic [31:0]   crc_q;
    logic [CW-1:0] line_width_q, line_count_q;

    logic vs_on, frame_edge, pix_act, line_end;

    assign vs_on      = vs_q ^ SYNC_IDLE;
    assign frame_edge = vs_on & ~vs_on_prev_q;
    assign pix_act    = ha_q & va_q;
    assign line_end   = ha_prev_q & ~ha_q & (pix_cnt_q != '0);

    always_comb begin
        crc_acc_d   = frame_edge ? CRC_INIT : crc_acc_q;
        if (pix_act) crc_acc_d = crc_step(crc_acc_d, pix_q);

        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        pend_w_d    = pend_w_q;
        pend_werr_d = pend_werr_q;
        if (line_end) begin
            pend_w_d    = pix_cnt_q;
            line_cnt_d  = (line_cnt_q == CNT_MAX) ? line_cnt_q : line_cnt_q + CW'(1);
            pend_werr_d = pend_werr_q | (pix_cnt_q != H_EXP);
            pix_cnt_d   = '0;
        end

        // A line ending in the edge cycle still belongs to the ending frame.
        snap_w     = pend_w_d;
        snap_lines = line_cnt_d;
        snap_werr  = pend_werr_d;

        if (frame_edge) begin
            pix_cnt_d   = '0;
            line_cnt_d  = '0;
            pend_werr_d = 1'b0;
        end
        if (pix_act && pix_cnt_d != CNT_MAX) pix_cnt_d = pix_cnt_d + CW'(1);
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            hs_q          <= SYNC_IDLE;
            vs_q          <= SYNC_IDLE;
            ha_q          <= 1'b0;
            va_q          <= 1'b0;
            pix_q         <= '0;
            vs_on_prev_q  <= 1'b0;
            ha_prev_q     <= 1'b0;
            crc_acc_q     <= CRC_INIT;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            pend_w_q      <= '0;
            pend_werr_q   <= 1'b0;
            done_pend_q   <= 1'b0;
            stg_crc_q     <= CRC_INIT;
            stg_w_q       <= '0;
            stg_lines_q   <= '0;
            stg_werr_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            crc_q         <= CRC_INIT;
            line_width_q  <= '0;
            line_count_q  <= '0;
            width_err_q   <= 1'b0;
            height_err_q  <= 1'b0;
        end else begin
            hs_q         <= hsync;
            vs_q         <= vsync;
            ha_q         <= hactive;
            va_q         <= vactive;
            pix_q        <= {red, green, blue};
            vs_on_prev_q <= vs_on;
            ha_prev_q    <= ha_q;
            crc_acc_q    <= crc_acc_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            pend_w_q     <= pend_w_d;
            pend_werr_q  <= pend_werr_d;
            done_pend_q  <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: if (frame_edge) state_q <= ST_RUN;
                ST_RUN: begin
                    if (frame_edge) begin
                        done_pend_q <= 1'b1;
                        stg_crc_q   <= crc_acc_q;
                        stg_w_q     <= snap_w;
                        stg_lines_q <= snap_lines;
                        stg_werr_q  <= snap_werr;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (done_pend_q) begin
                frame_done_q  <= 1'b1;
                frame_count_q <= frame_count_q + 16'd1;
                crc_q         <= stg_crc_q;
                line_width_q  <= stg_w_q;
                line_count_q  <= stg_lines_q;
                width_err_q   <= stg_werr_q;
                height_err_q  <= (stg_lines_q != V_EXP);
            end
        end
    end

    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign crc         = crc_q;
    assign line_width  = line_width_q;
    assign line_count  = line_count_q;
    assign width_err   = width_err_q;
    assign height_err  = height_err_q;

`ifdef VGA_FRAME_SIG_TIMING_EN
    logic          hs_on, hs_rise, hs_on_prev_q;
    logic [CW-1:0] h_cnt_q, h_last_q, v_cnt_q;
    logic [CW-1:0] stg_h_q, stg_v_q, h_total_q, v_total_q;

    assign hs_on   = hs_q ^ SYNC_IDLE;
    assign hs_rise = hs_on & ~hs_on_prev_q;

    // h_cnt_q holds cycles since the last hs_on rise, so it equals the period at the next rise.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hs_on_prev_q <= 1'b0;
            h_cnt_q      <= '0;
            h_last_q     <= '0;
            v_cnt_q      <= '0;
            stg_h_q      <= '0;
            stg_v_q      <= '0;
            h_total_q    <= '0;
            v_total_q    <= '0;
        end else begin
            hs_on_prev_q <= hs_on;
            if (hs_rise) begin
                h_last_q <= h_cnt_q;
                h_cnt_q  <= CW'(1);
            end else if (h_cnt_q != CNT_MAX) begin
                h_cnt_q  <= h_cnt_q + CW'(1);
            end

            if (frame_edge)                         v_cnt_q <= hs_rise ? CW'(1) : '0;
            else if (hs_rise && v_cnt_q != CNT_MAX) v_cnt_q <= v_cnt_q + CW'(1);

            if (frame_edge && state_q == ST_RUN) begin
                stg_h_q <= h_last_q;
                stg_v_q <= v_cnt_q;
            end
            if (done_pend_q) begin
                h_total_q <= stg_h_q;
                v_total_q <= stg_v_q;
            end
        end
    end

    assign h_total = h_total_q;
    assign v_total = v_total_q;
`else
    logic unused_hs;
    assign unused_hs = hs_q;
    assign h_total   = '0;
    assign v_total   = '0;
`endif

endmodule

// File: tb/tb_vga_frame_sig.sv
// Bench for vga_frame_sig: scaled-down video frames driven against a frame-level model
// (byte-table CRC-32 over the pixel stream, line-width lists), plus reset and frame_count wrap.
module tb_vga_frame_sig;

    localparam int HA = 16;
    localparam int VA = 6;
    localparam int CW = 12;
    localparam int LT = 24;
    localparam int VT = 10;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic          pclk, reset_n, hsync, vsync, hactive, vactive;
    logic [4:0]    red, blue;
    logic [5:0]    green;
    logic          frame_done, width_err, height_err;
    logic [15:0]   frame_count;
    logic [31:0]   crc;
    logic [CW-1:0] line_width, line_count, h_total, v_total;

    vga_frame_sig #(
        .RW(5), .GW(6), .BW(5), .H_ACTIVE(HA), .V_ACTIVE(VA), .CW(CW), .SYNC_NEG(1)
    ) dut (
        .pclk(pclk), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
        .hactive(hactive), .vactive(vactive), .red(red), .green(green), .blue(blue),
        .frame_done(frame_done), .frame_count(frame_count), .crc(crc),
        .line_width(line_width), .line_count(line_count), .width_err(width_err),
        .height_err(height_err), .h_total(h_total), .v_total(v_total)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulses = 0;
    int last_done_cyc = 0;
    int hold_viol = 0;
    logic [97:0] prev_vec = '0;
    logic        prev_rstn = 1'b0;
    logic [97:0] out_vec;

    logic [31:0]   cap_crc;
    logic [CW-1:0] cap_w, cap_lines, cap_ht, cap_vt;
    logic          cap_werr, cap_herr;
    logic [15:0]   cap_fc;

    assign out_vec = {frame_count, crc, line_width, line_count, width_err, height_err, h_total, v_total};

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (reset_n === 1'b1 && frame_done === 1'b1) begin
            pulses        <= pulses + 1;
            last_done_cyc <= cyc;
            cap_crc       <= crc;
            cap_w         <= line_width;
            cap_lines     <= line_count;
            cap_werr      <= width_err;
            cap_herr      <= height_err;
            cap_fc        <= frame_count;
            cap_ht        <= h_total;
            cap_vt        <= v_total;
        end
        if (reset_n === 1'b1 && prev_rstn === 1'b1 && frame_done !== 1'b1 && out_vec !== prev_vec)
            hold_viol <= hold_viol + 1;
        prev_vec  <= out_vec;
        prev_rstn <= reset_n;
    end

    logic [31:0] tbl [256];

    function automatic logic [31:0] tbl_entry(input int b);
        logic [31:0] c;
        c = 32'(b) << 24;
        repeat (8) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        return c;
    endfunction

    function automatic logic [31:0] crc_words(input logic [15:0] q[$]);
        logic [31:0] c;
        logic [7:0]  by;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            by = q[i][15:8];
            c  = (c << 8) ^ tbl[c[31:24] ^ by];
            by = q[i][7:0];
            c  = (c << 8) ^ tbl[c[31:24] ^ by];
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_done"},   32'(frame_done),  0);
        chk({tag, "_fc"},     32'(frame_count), 0);
        chk({tag, "_crc"},    crc,              32'hFFFFFFFF);
        chk({tag, "_width"},  32'(line_width),  0);
        chk({tag, "_lines"},  32'(line_count),  0);
        chk({tag, "_werr"},   32'(width_err),   0);
        chk({tag, "_herr"},   32'(height_err),  0);
        chk({tag, "_htotal"}, 32'(h_total),     0);
        chk({tag, "_vtotal"}, 32'(v_total),     0);
    endtask

    // Model state: expectations for the frame whose result the next pulse reports.
    int          model_run = 0;
    int          rst_in_frame = 0;
    logic [15:0] fc_model = '0;
    int          frame_p0 = 0;
    int          drive_cyc = 0;
    logic [31:0] exp_crc, nxt_crc;
    int          exp_w, nxt_w, exp_lines, nxt_lines;
    logic        exp_werr, nxt_werr, exp_herr, nxt_herr;

    task automatic send_frame(input int mode, input int nact, input int short_idx,
                              input int short_w, input int rst_line);
        int          w[$];
        logic [15:0] words[$];
        logic [4:0]  r, b;
        logic [5:0]  g;
        int          li, x, ww;
        logic        any_bad;
        any_bad = 1'b0;
        for (int l = 0; l < nact; l++) begin
            ww = HA;
            if (mode == 3) ww = HA - 1 + int'($urandom_range(2));
            if (l == short_idx) ww = short_w;
            if (ww != HA) any_bad = 1'b1;
            w.push_back(ww);
        end
        frame_p0 = pulses;
        for (int l = 0; l < VT; l++) begin
            for (int c = 0; c < LT; c++) begin
                li = l - 2;
                x  = c - 2;
                vactive = (li >= 0 && li < nact);
                hactive = 1'b0;
                if (vactive) hactive = (x >= 0 && x < w[li]);
                r = '0; g = '0; b = '0;
                if (hactive) begin
                    if (mode == 1 || mode == 2) begin
                        r = 5'(x);
                        g = 6'(x + 3 * li);
                        b = 5'(li);
                        if (mode == 2 && li == 1 && x == 5) r = r ^ 5'd1;
                    end else if (mode == 3) begin
                        r = 5'($urandom);
                        g = 6'($urandom);
                        b = 5'($urandom);
                    end
                    words.push_back({r, g, b});
                end
                red = r; green = g; blue = b;
                vsync = (l == 0) ? 1'b0 : 1'b1;
                hsync = (c >= 20 && c < 22) ? 1'b0 : 1'b1;
                if (l == 0 && c == 0) drive_cyc = cyc;
                if (l == rst_line && c == 3) begin
                    reset_n = 1'b0;
                    #1;
                    chk_reset("midrst");
                    rst_in_frame = 1;
                end
                if (l == rst_line && c == 8) reset_n = 1'b1;
                tick();
            end
        end
        nxt_crc   = crc_words(words);
        nxt_w     = w[nact-1];
        nxt_lines = nact;
        nxt_werr  = any_bad;
        nxt_herr  = (nact != VA);
    endtask

    task automatic finish_frame();
        if (model_run != 0) begin
            fc_model = fc_model + 16'd1;
            chk("done_pulses", 32'(pulses - frame_p0), 1);
            chk("latency",     32'(last_done_cyc - drive_cyc), 3);
            chk("crc",         cap_crc, exp_crc);
            chk("line_width",  32'(cap_w), 32'(exp_w));
            chk("line_count",  32'(cap_lines), 32'(exp_lines));
            chk("width_err",   32'(cap_werr), 32'(exp_werr));
            chk("height_err",  32'(cap_herr), 32'(exp_herr));
            chk("frame_count", 32'(cap_fc), 32'(fc_model));
`ifdef VGA_FRAME_SIG_TIMING_EN
            chk("h_total",     32'(cap_ht), LT);
            chk("v_total",     32'(cap_vt), VT);
`else
            chk("h_total",     32'(cap_ht), 0);
            chk("v_total",     32'(cap_vt), 0);
`endif
        end else begin
            chk("no_done", 32'(pulses - frame_p0), 0);
        end
        if (rst_in_frame != 0) begin
            model_run    = 0;
            fc_model     = '0;
            rst_in_frame = 0;
        end else begin
            model_run = 1;
        end
        exp_crc   = nxt_crc;
        exp_w     = nxt_w;
        exp_lines = nxt_lines;
        exp_werr  = nxt_werr;
        exp_herr  = nxt_herr;
    endtask

    initial begin
        logic [31:0] crc_a, crc_b, crc_c;
        int          p, n;
        for (int i = 0; i < 256; i++) tbl[i] = tbl_entry(i);
        reset_n = 1'b0;
        hsync = 1'b1; vsync = 1'b1; hactive = 1'b0; vactive = 1'b0;
        red = '0; green = '0; blue = '0;
        repeat (3) tick();
        chk_reset("por");
        reset_n = 1'b1;
        tick();

        // Three constant-zero frames: two pulses.
        send_frame(0, VA, -1, 0, -1); finish_frame();
        send_frame(0, VA, -1, 0, -1); finish_frame();
        send_frame(1, VA, -1, 0, -1); finish_frame();
        chk("fc_after_three", 32'(cap_fc), 2);

        // Ramp, identical ramp, ramp with one altered pixel.
        send_frame(1, VA, -1, 0, -1); finish_frame(); crc_a = cap_crc;
        send_frame(2, VA, -1, 0, -1); finish_frame(); crc_b = cap_crc;
        send_frame(0, VA,  3, HA - 1, -1); finish_frame(); crc_c = cap_crc;
        chk("crc_repeat", crc_b, crc_a);
        chk("crc_differs", 32'(crc_c != crc_b), 1);

        // Short line frame, then clean, then one line missing, then random content.
        send_frame(0, VA, -1, 0, -1); finish_frame();
        send_frame(0, VA - 1, -1, 0, -1); finish_frame();
        send_frame(3, VA, -1, 0, -1); finish_frame();
        send_frame(3, VA, -1, 0, -1); finish_frame();

        // Reset mid-frame: next edge silent, following edge pulses.
        send_frame(3, VA, -1, 0, 4); finish_frame();
        send_frame(1, VA, -1, 0, -1); finish_frame();
        send_frame(0, VA, -1, 0, -1); finish_frame();

        // Inputs stuck: no pulses.
        p = pulses;
        vsync = 1'b1; hsync = 1'b1; hactive = 1'b1; vactive = 1'b1;
        repeat (60) tick();
        chk("stuck_no_done", 32'(pulses - p), 0);

        // Minimal two-cycle frames until frame_count wraps to zero.
        hactive = 1'b0; vactive = 1'b0;
        p = pulses;
        n = 65536 - int'(fc_model);
        for (int i = 0; i < n; i++) begin
            vsync = 1'b0; tick();
            vsync = 1'b1; tick();
        end
        repeat (5) tick();
        chk("wrap_pulses", 32'(pulses - p), 32'(n));
        chk("wrap_count",  32'(frame_count), 0);
        chk("tiny_lines",  32'(line_count), 0);
        chk("tiny_herr",   32'(height_err), 1);
        chk("hold_between_pulses", 32'(hold_viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_sig.md
VGA_FRAME_SIG -- requirements
Module: vga_frame_sig

Interface
REQ-001 The block SHALL have parameters (name, default, meaning):
- RW, 5: red width
- GW, 6: green width
- BW, 5: blue width
- H_ACTIVE, 640: expected active pixels per line
- V_ACTIVE, 480: expected active lines per frame
- CW, 12: width of all pixel and line counters
- SYNC_NEG, 1: 1 means hsync/vsync are asserted low.

REQ-002 The block SHALL have ports (name, direction, width, meaning):
- pclk, in, 1: pixel clock; the only clock
- reset_n, in, 1: asynchronous active-low reset
- hsync, in, 1: horizontal sync
- vsync, in, 1: vertical sync
- hactive, in, 1: horizontal active
- vactive, in, 1: vertical active
- red, in, RW: red pixel component
- green, in, GW: green pixel component
- blue, in, BW: blue pixel component
- frame_done, out, 1: one-cycle frame-complete pulse
- frame_count, out, 16: number of completed frames
- crc, out, 32: CRC of the last completed frame
- line_width, out, CW: active pixels in the last active line of the last frame
- line_count, out, CW: active lines in the last frame
- width_err, out, 1: any line width differed from H_ACTIVE
- height_err, out, 1: line_count differed from V_ACTIVE
- h_total, out, CW: pclk cycles per line
- v_total, out, CW: lines per frame

Function
REQ-003 All inputs except reset_n SHALL be registered once on pclk (stage S1) before any use; all logic SHALL use S1 values.
REQ-004 "vs_on" SHALL be S1 vsync XOR SYNC_NEG; the frame edge SHALL be vs_on rising (previous S1 0, current S1 1); "hs_on" SHALL be defined the same way from hsync.
REQ-005 The state machine SHALL have states IDLE (reset) and RUN.
- IDLE to RUN on the first frame edge, with no frame_done.
- RUN stays in RUN on every later frame edge.
REQ-006 A pixel SHALL be active when S1 hactive and S1 vactive are both 1.
REQ-007 The per-frame CRC accumulator SHALL be CRC-32:
- polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR
- updated once per active pixel over the word {red,green,blue} (RW+GW+BW bits), MSB first
- computed entirely within one cycle.
REQ-008 The pixel counter SHALL increment per active pixel and saturate at 2^CW-1.
REQ-009 On each S1 hactive falling edge with a nonzero pixel count, the block SHALL:
- latch the count as the pending line width
- increment the active-line counter (saturating)
- set the pending width error if the count differs from H_ACTIVE
- clear the pixel counter.
REQ-010 On a frame edge while in RUN, in the next cycle the block SHALL:
- pulse frame_done high for exactly one cycle
- load crc, line_width, line_count and width_err from the pending values
- set height_err to (line_count != V_ACTIVE)
- increment frame_count, wrapping from 0xFFFF to 0.
REQ-011 On every frame edge (IDLE or RUN), the block SHALL reinitialise the CRC accumulator, pixel counter, line counter and pending width error.
- An active pixel in the edge cycle SHALL belong to the new frame.
REQ-012 Between frame_done pulses, the outputs of REQ-010 SHALL hold their values unchanged.
REQ-013 Latency SHALL be exactly 3 pclk edges from the first pclk edge sampling vsync asserted to frame_done high.
REQ-014 An hactive falling edge coinciding with a frame edge SHALL complete that line into the ending frame before the snapshot.
REQ-015 Sync or active inputs stuck constant SHALL produce no frame_done and no counter wrap except saturation.

Reset
REQ-016 While reset_n is 0, the block SHALL immediately force:
- state IDLE
- frame_done, frame_count, line_width, line_count, width_err, height_err, h_total and v_total to 0
- crc to 0xFFFFFFFF
- all S1 registers to the deasserted sync level (SYNC_NEG) and 0 for the others.
REQ-017 Reset asserted mid-frame SHALL discard the partial frame; after release, the first frame edge SHALL NOT pulse frame_done.

Configuration
REQ-018 When macro VGA_FRAME_SIG_TIMING_EN is defined, the block SHALL measure timing:
- h_total: pclk cycles between consecutive hs_on rising edges (saturating)
- v_total: hs_on rising edges between consecutive frame edges (saturating)
- both SHALL update on the frame_done cycle from the completed frame.
REQ-019 When VGA_FRAME_SIG_TIMING_EN is undefined, h_total and v_total SHALL be constant 0 and no timing counters SHALL be synthesised.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- 640x480 timing, 800x525 totals, constant pixel 0, three frames -> frame_done once per frame after the first edge (two pulses), line_width=640, line_count=480, both errors 0, frame_count=2, and with TIMING_EN h_total=800 and v_total=525.
- Two identical frames with a red/green/blue ramp -> equal crc values; one changed pixel in the next frame -> different crc.
- One line shortened to 639 pixels -> width_err=1 for that frame only; next clean frame -> width_err=0.
- 479 active lines -> height_err=1 and line_count=479.
- reset_n low for 5 cycles mid-frame -> all outputs at reset values on the same cycle; no frame_done at the next edge; frame_done at the following edge.
- frame_count preloaded by running 65536 frames of tiny timing (H_ACTIVE=4, V_ACTIVE=2) -> frame_count wraps to 0.
